// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encodings and
// the width of the re-sequence event counter.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int RST_COUNT_W = 8;

endpackage

// File: rtl/rst_seq_sync.sv
// Generic multi-flop synchronizer with asynchronous active-low clear; used both
// for reset-release synchronization and for bringing lock status into clk domain.
module rst_seq_sync #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: waits for synchronized reset release and a filtered
// lock indication, then releases NUM_STAGES resets in order with fixed spacing.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_FILTER = 8,
    parameter int SYNC_DEPTH  = 2
) (
    input  logic                   clk_sys_i,
    input  logic                   rstn_i,
    input  logic                   locked_i,
    input  logic                   sw_rst_i,
    output logic [NUM_STAGES-1:0]  rstn_stage_o,
    output logic                   ready_o,
    output logic [1:0]             state_o,
    output logic [RST_COUNT_W-1:0] rst_count_o
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int DLY_W  = $clog2(STAGE_DELAY + 1);
    localparam int IDX_W  = $clog2(NUM_STAGES + 1);

    logic w_rst_sync_n;
    logic w_locked_s;
    logic w_abort;
    logic w_filt_done;
    logic w_dly_done;
    logic w_last_stage;

    state_e                 r_state;
    logic [FILT_W-1:0]      r_filt;
    logic [DLY_W-1:0]       r_dly;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_STAGES-1:0]  r_stage;
    logic                   r_ready;
    logic [RST_COUNT_W-1:0] r_count;

    rst_seq_sync #(
        .DEPTH(SYNC_DEPTH)
    ) u_rst_sync (
        .i_clk (clk_sys_i),
        .i_rstn(rstn_i),
        .i_d   (1'b1),
        .o_q   (w_rst_sync_n)
    );

    rst_seq_sync #(
        .DEPTH(SYNC_DEPTH)
    ) u_lock_sync (
        .i_clk (clk_sys_i),
        .i_rstn(rstn_i),
        .i_d   (locked_i),
        .o_q   (w_locked_s)
    );

    assign w_abort      = !w_locked_s || sw_rst_i;
    assign w_filt_done  = (r_filt == FILT_W'(LOCK_FILTER - 1));
    assign w_dly_done   = (r_dly == DLY_W'(STAGE_DELAY - 1));
    assign w_last_stage = (r_idx == IDX_W'(NUM_STAGES - 1));

    always_ff @(posedge clk_sys_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= RESET;
            r_filt  <= '0;
            r_dly   <= '0;
            r_idx   <= '0;
            r_stage <= '0;
            r_ready <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                RESET: begin
                    if (w_rst_sync_n) begin
                        r_state <= WAIT_LOCK;
                    end
                end

                WAIT_LOCK: begin
                    if (w_abort) begin
                        r_filt <= '0;
                    end else if (w_filt_done) begin
                        r_filt  <= '0;
                        r_dly   <= '0;
                        r_idx   <= '0;
                        r_state <= RELEASE;
                    end else begin
                        r_filt <= r_filt + FILT_W'(1);
                    end
                end

                RELEASE, RUN: begin
                    // Abort wins over a stage release falling on the same edge.
                    if (w_abort) begin
                        r_stage <= '0;
                        r_ready <= 1'b0;
                        r_filt  <= '0;
                        r_state <= WAIT_LOCK;
                        if (r_count != '1) begin
                            r_count <= r_count + RST_COUNT_W'(1);
                        end
                    end else if (r_state == RELEASE) begin
                        if (w_dly_done) begin
                            // Stages release strictly in order, so a shift-in of ones suffices.
                            r_stage <= (r_stage << 1) | NUM_STAGES'(1);
                            r_idx   <= r_idx + IDX_W'(1);
                            r_dly   <= '0;
                            if (w_last_stage) begin
                                r_state <= RUN;
                                r_ready <= 1'b1;
                            end
                        end else begin
                            r_dly <= r_dly + DLY_W'(1);
                        end
                    end
                end

                default: r_state <= RESET;
            endcase
        end
    end

    assign rstn_stage_o = r_stage;
    assign ready_o      = r_ready;
    assign state_o      = r_state;
    assign rst_count_o  = r_count;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: expected output snapshots are queued per edge
// as stimulus is driven and compared #1 after each rising clock edge.
module tb_rst_seq_gen;

    localparam int NS  = 3;
    localparam int SD  = 2;
    localparam int LF  = 8;
    localparam int DLY = 16;

    localparam logic [1:0] S_RST = 2'd0;
    localparam logic [1:0] S_WL  = 2'd1;
    localparam logic [1:0] S_REL = 2'd2;
    localparam logic [1:0] S_RUN = 2'd3;

    logic          clk_sys_i = 1'b0;
    logic          rstn_i    = 1'b0;
    logic          locked_i  = 1'b1;
    logic          sw_rst_i  = 1'b0;
    logic [NS-1:0] rstn_stage_o;
    logic          ready_o;
    logic [1:0]    state_o;
    logic [7:0]    rst_count_o;

    always #5 clk_sys_i = ~clk_sys_i;

    rst_seq_gen #(
        .NUM_STAGES (NS),
        .STAGE_DELAY(DLY),
        .LOCK_FILTER(LF),
        .SYNC_DEPTH (SD)
    ) dut (
        .clk_sys_i   (clk_sys_i),
        .rstn_i      (rstn_i),
        .locked_i    (locked_i),
        .sw_rst_i    (sw_rst_i),
        .rstn_stage_o(rstn_stage_o),
        .ready_o     (ready_o),
        .state_o     (state_o),
        .rst_count_o (rst_count_o)
    );

    typedef struct {
        int          e;
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];
    int   edge_n  = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [13:0] mk(logic [2:0] st, logic rdy, logic [1:0] s, logic [7:0] c);
        return {st, rdy, s, c};
    endfunction

    task automatic expect_at(int e, string tag, logic [13:0] v);
        exp_t it;
        int   i;
        it.e   = e;
        it.tag = tag;
        it.v   = v;
        i = 0;
        while (i < sb.size() && sb[i].e <= e) i++;
        sb.insert(i, it);
    endtask

    task automatic compare(string tag, logic [13:0] exp_v);
        logic [13:0] obs;
        obs = {rstn_stage_o, ready_o, state_o, rst_count_o};
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s @edge %0d: got stage=%b ready=%b state=%0d cnt=%0d, expected stage=%b ready=%b state=%0d cnt=%0d",
                    tag, edge_n, obs[13:11], obs[10], obs[9:8], obs[7:0],
                    exp_v[13:11], exp_v[10], exp_v[9:8], exp_v[7:0]);
    endtask

    task automatic tick();
        exp_t it;
        @(posedge clk_sys_i);
        edge_n++;
        #1;
        while (sb.size() > 0 && sb[0].e <= edge_n) begin
            it = sb.pop_front();
            compare(it.tag, it.v);
        end
    endtask

    task automatic run_to(int e);
        while (edge_n < e) tick();
    endtask

    // Edge 0 is the rising edge just before rstn_i is released (1 time unit later).
    task automatic release_reset();
        @(posedge clk_sys_i);
        edge_n = 0;
        #1 rstn_i = 1'b1;
    endtask

    task automatic powerup_expect(string p);
        expect_at(2,  {p, "_still_reset"}, mk(3'b000, 1'b0, S_RST, 8'd0));
        expect_at(3,  {p, "_wait_lock"},   mk(3'b000, 1'b0, S_WL,  8'd0));
        expect_at(10, {p, "_pre_release"}, mk(3'b000, 1'b0, S_WL,  8'd0));
        expect_at(11, {p, "_release"},     mk(3'b000, 1'b0, S_REL, 8'd0));
        expect_at(26, {p, "_pre_stage0"},  mk(3'b000, 1'b0, S_REL, 8'd0));
        expect_at(27, {p, "_stage0"},      mk(3'b001, 1'b0, S_REL, 8'd0));
        expect_at(42, {p, "_pre_stage1"},  mk(3'b001, 1'b0, S_REL, 8'd0));
        expect_at(43, {p, "_stage1"},      mk(3'b011, 1'b0, S_REL, 8'd0));
        expect_at(58, {p, "_pre_stage2"},  mk(3'b011, 1'b0, S_REL, 8'd0));
        expect_at(59, {p, "_run"},         mk(3'b111, 1'b1, S_RUN, 8'd0));
        expect_at(62, {p, "_run_hold"},    mk(3'b111, 1'b1, S_RUN, 8'd0));
    endtask

    initial begin
        int e0, r0, s0, h0, a0;
        logic [7:0] c;

        // Power-up
        #1 compare("reset_vals", mk(3'b000, 1'b0, S_RST, 8'd0));
        repeat (3) @(posedge clk_sys_i);
        #1 compare("reset_vals_clocked", mk(3'b000, 1'b0, S_RST, 8'd0));
        release_reset();
        powerup_expect("pu");
        run_to(62);

        // Lock loss in RUN, then restore
        e0 = edge_n;
        locked_i = 1'b0;
        expect_at(e0 + SD, "lockloss_hold", mk(3'b111, 1'b1, S_RUN, 8'd0));
        expect_at(e0 + SD + 1, "lockloss_abort", mk(3'b000, 1'b0, S_WL, 8'd1));
        run_to(e0 + SD + 2);
        r0 = edge_n;
        locked_i = 1'b1;
        expect_at(r0 + SD + LF - 1, "relock_pre_release", mk(3'b000, 1'b0, S_WL, 8'd1));
        expect_at(r0 + SD + LF, "relock_release", mk(3'b000, 1'b0, S_REL, 8'd1));
        expect_at(r0 + SD + LF + DLY, "relock_stage0", mk(3'b001, 1'b0, S_REL, 8'd1));
        expect_at(r0 + SD + LF + 2 * DLY, "relock_stage1", mk(3'b011, 1'b0, S_REL, 8'd1));
        expect_at(r0 + SD + LF + 3 * DLY - 1, "relock_pre_run", mk(3'b011, 1'b0, S_REL, 8'd1));
        expect_at(r0 + SD + LF + 3 * DLY, "relock_run", mk(3'b111, 1'b1, S_RUN, 8'd1));
        run_to(r0 + SD + LF + 3 * DLY + 2);

        // sw_rst_i pulse from RUN, then sw_rst_i held across a stage-release edge
        s0 = edge_n + 1;
        expect_at(s0, "sw_abort_run", mk(3'b000, 1'b0, S_WL, 8'd2));
        expect_at(s0 + LF, "sw_release", mk(3'b000, 1'b0, S_REL, 8'd2));
        expect_at(s0 + LF + DLY - 1, "sw_pre_stage0", mk(3'b000, 1'b0, S_REL, 8'd2));
        h0 = s0 + LF + DLY;
        expect_at(h0, "sw_blocks_stage0", mk(3'b000, 1'b0, S_WL, 8'd3));
        expect_at(h0 + 11, "sw_held_wait", mk(3'b000, 1'b0, S_WL, 8'd3));
        expect_at(h0 + 11 + LF - 1, "sw_after_pre_rel", mk(3'b000, 1'b0, S_WL, 8'd3));
        expect_at(h0 + 11 + LF, "sw_after_release", mk(3'b000, 1'b0, S_REL, 8'd3));
        expect_at(h0 + 11 + LF + DLY, "sw_after_stage0", mk(3'b001, 1'b0, S_REL, 8'd3));
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        run_to(h0 - 1);
        sw_rst_i = 1'b1;
        run_to(h0 + 11);
        sw_rst_i = 1'b0;
        run_to(h0 + 11 + LF + DLY + 4);

        // rstn_i asserted mid-RELEASE: immediate clear, then identical power-up
        rstn_i = 1'b0;
        #1 compare("async_clear", mk(3'b000, 1'b0, S_RST, 8'd0));
        repeat (2) @(posedge clk_sys_i);
        release_reset();
        powerup_expect("re");
        run_to(62);

        // Lock glitch during WAIT_LOCK after 5 filtered-high edges
        rstn_i = 1'b0;
        repeat (2) @(posedge clk_sys_i);
        release_reset();
        expect_at(11, "glitch_no_release", mk(3'b000, 1'b0, S_WL, 8'd0));
        expect_at(11 + 5 + 1 + SD - 1, "glitch_pre_release", mk(3'b000, 1'b0, S_WL, 8'd0));
        expect_at(11 + 5 + 1 + SD, "glitch_release", mk(3'b000, 1'b0, S_REL, 8'd0));
        expect_at(11 + 5 + 1 + SD + DLY, "glitch_stage0", mk(3'b001, 1'b0, S_REL, 8'd0));
        expect_at(11 + 5 + 1 + SD + 3 * DLY, "glitch_run", mk(3'b111, 1'b1, S_RUN, 8'd0));
        run_to(8);
        locked_i = 1'b0;
        run_to(9);
        locked_i = 1'b1;
        run_to(11 + 5 + 1 + SD + 3 * DLY + 1);

        // Saturation: 260 aborts from RUN
        for (int n = 1; n <= 260; n++) begin
            c  = (n > 255) ? 8'd255 : 8'(n);
            a0 = edge_n + 1;
            expect_at(a0, "sat_abort", mk(3'b000, 1'b0, S_WL, c));
            expect_at(a0 + LF + 3 * DLY, "sat_run", mk(3'b111, 1'b1, S_RUN, c));
            sw_rst_i = 1'b1;
            tick();
            sw_rst_i = 1'b0;
            run_to(a0 + LF + 3 * DLY);
        end
        compare("sat_final", mk(3'b111, 1'b1, S_RUN, 8'd255));

        n_total++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
